// File: rtl/tcm_responder.sv
// Shared 32-bit instruction/data TCM: registered instruction read port plus a bit-masked data read/write port.
// Optional macro TCM_INIT_CLEAR_EN adds a post-reset sweep that zeroes every word before accesses are accepted.
module tcm_responder #(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] IM_r_addr,
  input  logic        IM_ready,
  output logic [31:0] IM_r_data,
  input  logic        DM_c_en,
  input  logic        DM_r_en,
  input  logic [31:0] DM_w_en,
  input  logic [31:0] DM_addr,
  input  logic [31:0] DM_w_data,
  output logic [31:0] DM_rd_data,
  output logic        mem_busy,
  output logic        dm_oob_err
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [0:0] S_INIT = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [31:0]           r_mem [0:DEPTH-1];
  logic [0:0]            r_state;
  logic [DEPTH_LOG2-1:0] w_im_idx;
  logic [DEPTH_LOG2-1:0] w_dm_idx;
  logic [DEPTH_LOG2-1:0] w_sweep_idx;
  logic                  w_run;
  logic                  w_oob;
  logic                  w_dm_rd;
  logic                  w_dm_wr;
  logic                  w_sweep_we;
  logic                  w_unused;

  assign w_im_idx = IM_r_addr[DEPTH_LOG2+1:2];
  assign w_dm_idx = DM_addr[DEPTH_LOG2+1:2];
  assign w_oob    = |DM_addr[31:DEPTH_LOG2+2];
  assign w_run    = (r_state != S_INIT);
  assign w_dm_rd  = w_run && DM_c_en && DM_r_en;
  // rst gates the array write because the array itself has no reset path
  assign w_dm_wr  = w_run && rst && DM_c_en && !DM_r_en && !w_oob;
  // Byte-offset bits and instruction address bits above the index wrap away by design
  assign w_unused = ^{IM_r_addr, DM_addr[1:0]};

`ifdef TCM_INIT_CLEAR_EN
  logic [DEPTH_LOG2-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_INIT;
      r_cnt   <= '0;
    end else if (r_state == S_INIT) begin
      r_cnt <= r_cnt + 1'b1;
      if (r_cnt == '1) begin
        r_state <= S_RUN;
      end
    end
  end

  assign w_sweep_we  = !w_run && rst;
  assign w_sweep_idx = r_cnt;
  assign mem_busy    = !w_run;
`else
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_RUN;
    end else begin
      r_state <= r_state;
    end
  end

  assign w_sweep_we  = 1'b0;
  assign w_sweep_idx = '0;
  assign mem_busy    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (w_sweep_we) begin
      r_mem[w_sweep_idx] <= '0;
    end else if (w_dm_wr) begin
      r_mem[w_dm_idx] <= (r_mem[w_dm_idx] & ~DM_w_en) | (DM_w_data & DM_w_en);
    end
  end

  // Reads sample the array before this edge's write lands, giving read-before-write
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      IM_r_data  <= '0;
      DM_rd_data <= '0;
      dm_oob_err <= 1'b0;
    end else begin
      if (w_run && IM_ready) begin
        IM_r_data <= r_mem[w_im_idx];
      end
      if (w_dm_rd) begin
        DM_rd_data <= w_oob ? 32'h0 : r_mem[w_dm_idx];
      end
      if (w_run && DM_c_en && w_oob) begin
        dm_oob_err <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_tcm_responder.sv
// Bench for tcm_responder: a 16-word and a 1024-word instance share one stimulus bus, each with its own reset.
// Expected read data is queued when a request is driven and popped when the registered output appears.
module tb_tcm_responder;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst4, rst10;
  logic [15:0] im_addr;
  logic        im_ready;
  logic        dm_c_en, dm_r_en;
  logic [31:0] dm_w_en, dm_addr, dm_w_data;
  logic [31:0] im_data4, dm_data4, im_data10, dm_data10;
  logic        busy4, oob4, busy10, oob10;

`ifdef TCM_INIT_CLEAR_EN
  localparam bit SWEEP   = 1'b1;
  localparam int SWEEP4  = 16;
  localparam int SWEEP10 = 1024;
`else
  localparam bit SWEEP   = 1'b0;
  localparam int SWEEP4  = 0;
  localparam int SWEEP10 = 0;
`endif

  tcm_responder #(.DEPTH_LOG2(4)) dut4 (
    .clk(clk), .rst(rst4), .IM_r_addr(im_addr), .IM_ready(im_ready), .IM_r_data(im_data4),
    .DM_c_en(dm_c_en), .DM_r_en(dm_r_en), .DM_w_en(dm_w_en), .DM_addr(dm_addr),
    .DM_w_data(dm_w_data), .DM_rd_data(dm_data4), .mem_busy(busy4), .dm_oob_err(oob4)
  );

  tcm_responder #(.DEPTH_LOG2(10)) dut10 (
    .clk(clk), .rst(rst10), .IM_r_addr(im_addr), .IM_ready(im_ready), .IM_r_data(im_data10),
    .DM_c_en(dm_c_en), .DM_r_en(dm_r_en), .DM_w_en(dm_w_en), .DM_addr(dm_addr),
    .DM_w_data(dm_w_data), .DM_rd_data(dm_data10), .mem_busy(busy10), .dm_oob_err(oob10)
  );

  int          errors = 0;
  int          checks = 0;
  logic [31:0] im_q[$];
  logic [31:0] dm_q[$];
  logic [31:0] dm10_q[$];
  logic [31:0] mdl [0:15];
  logic [31:0] exp_v;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic bus_idle();
    im_ready = 1'b0;
    dm_c_en  = 1'b0;
    dm_r_en  = 1'b0;
    dm_w_en  = 32'h0;
  endtask

  task automatic drive_dm_write(input logic [31:0] addr, input logic [31:0] data, input logic [31:0] wen);
    dm_c_en = 1'b1; dm_r_en = 1'b0; dm_addr = addr; dm_w_data = data; dm_w_en = wen;
    if (addr[31:6] == 26'h0) mdl[addr[5:2]] = (mdl[addr[5:2]] & ~wen) | (data & wen);
  endtask

  task automatic drive_dm_read(input logic [31:0] addr);
    dm_c_en = 1'b1; dm_r_en = 1'b1; dm_addr = addr; dm_w_en = 32'h0;
    dm_q.push_back((addr[31:6] == 26'h0) ? mdl[addr[5:2]] : 32'h0);
  endtask

  task automatic drive_im_read(input logic [15:0] addr);
    im_ready = 1'b1; im_addr = addr;
    im_q.push_back(mdl[addr[5:2]]);
  endtask

  task automatic test_reset();
    rst4 = 1'b0; rst10 = 1'b0; im_addr = 16'h0; dm_addr = 32'h0; dm_w_data = 32'h0;
    bus_idle();
    for (int i = 0; i < 16; i++) mdl[i] = 32'h0;
    tick(); tick();
    checks++; if (im_data4 !== 32'h0) begin errors++; $display("FAIL reset_im: got %08h want 00000000", im_data4); end
    checks++; if (dm_data4 !== 32'h0) begin errors++; $display("FAIL reset_dm: got %08h want 00000000", dm_data4); end
    checks++; if (oob4 !== 1'b0) begin errors++; $display("FAIL reset_oob: got %b want 0", oob4); end
    checks++; if (busy4 !== SWEEP) begin errors++; $display("FAIL reset_busy: got %b want %b", busy4, SWEEP); end
    $display("reset: im=%08h dm=%08h busy=%b oob=%b", im_data4, dm_data4, busy4, oob4);
  endtask

  task automatic test_sweep();
    int n;
    rst4 = 1'b1;
    n = 0;
    while (busy4 === 1'b1 && n < 100) begin n++; tick(); end
    checks++; if (n != SWEEP4) begin errors++; $display("FAIL sweep_len: got %0d cycles want %0d", n, SWEEP4); end
    $display("sweep: busy for %0d cycles", n);
    if (!SWEEP) begin
      for (int i = 0; i < 16; i++) begin drive_dm_write(32'(i * 4), 32'h0, 32'hFFFF_FFFF); tick(); end
      bus_idle();
    end
    for (int i = 0; i < 16; i++) begin
      drive_dm_read(32'(i * 4));
      drive_im_read(16'(i * 4));
      tick();
      exp_v = dm_q.pop_front();
      checks++; if (dm_data4 !== exp_v) begin errors++; $display("FAIL sweep_dm[%0d]: got %08h want %08h", i, dm_data4, exp_v); end
      exp_v = im_q.pop_front();
      checks++; if (im_data4 !== exp_v) begin errors++; $display("FAIL sweep_im[%0d]: got %08h want %08h", i, im_data4, exp_v); end
      $display("read word %0d: dm=%08h im=%08h", i, dm_data4, im_data4);
    end
    bus_idle();
  endtask

  task automatic test_write_mask();
    drive_dm_write(32'h8, 32'hDEAD_BEEF, 32'hFFFF_FFFF); tick();
    checks++; if (dm_data4 !== 32'h0) begin errors++; $display("FAIL wr_hold: got %08h want 00000000", dm_data4); end
    drive_dm_write(32'h8, 32'h1234_5678, 32'h0000_FFFF); tick();
    drive_dm_read(32'h8); tick();
    exp_v = dm_q.pop_front();
    checks++; if (dm_data4 !== exp_v || dm_data4 !== 32'hDEAD_5678) begin
      errors++; $display("FAIL wr_mask: got %08h want DEAD5678", dm_data4);
    end
    $display("masked write/read 0x8: %08h", dm_data4);
    dm_c_en = 1'b0; dm_r_en = 1'b1; dm_addr = 32'h0; tick();
    checks++; if (dm_data4 !== 32'hDEAD_5678) begin errors++; $display("FAIL cen_hold: got %08h want DEAD5678", dm_data4); end
    drive_dm_read(32'h0000_000B); tick();
    exp_v = dm_q.pop_front();
    checks++; if (dm_data4 !== exp_v) begin errors++; $display("FAIL low_bits: got %08h want %08h", dm_data4, exp_v); end
    bus_idle();
  endtask

  task automatic test_rbw();
    drive_im_read(16'h0010);
    drive_dm_write(32'h10, 32'hA5A5_A5A5, 32'hFFFF_FFFF);
    tick();
    exp_v = im_q.pop_front();
    checks++; if (im_data4 !== exp_v) begin errors++; $display("FAIL rbw_old: got %08h want %08h", im_data4, exp_v); end
    $display("rbw same cycle: im=%08h", im_data4);
    bus_idle();
    drive_im_read(16'h0010); tick();
    exp_v = im_q.pop_front();
    checks++; if (im_data4 !== exp_v) begin errors++; $display("FAIL rbw_new: got %08h want %08h", im_data4, exp_v); end
    drive_im_read(16'hFF53); tick();
    exp_v = im_q.pop_front();
    checks++; if (im_data4 !== exp_v) begin errors++; $display("FAIL im_wrap: got %08h want %08h", im_data4, exp_v); end
    $display("rbw next read: im=%08h", im_data4);
    bus_idle();
  endtask

  task automatic test_im_hold();
    for (int k = 0; k < 5; k++) begin
      im_ready = 1'b0;
      im_addr  = 16'(8 + 4 * k);
      im_q.push_back(32'hA5A5_A5A5);
      tick();
      exp_v = im_q.pop_front();
      checks++; if (im_data4 !== exp_v) begin errors++; $display("FAIL im_hold[%0d]: got %08h want %08h", k, im_data4, exp_v); end
      $display("im idle cycle %0d: im=%08h", k, im_data4);
    end
  endtask

  task automatic test_oob();
    int n;
    rst10 = 1'b1;
    n = 0;
    while (busy10 === 1'b1 && n < 2000) begin n++; tick(); end
    checks++; if (n != SWEEP10) begin errors++; $display("FAIL sweep10_len: got %0d cycles want %0d", n, SWEEP10); end
    drive_dm_write(32'h0, 32'h0, 32'hFFFF_FFFF); tick();
    drive_dm_write(32'h8, 32'h55AA_00FF, 32'hFFFF_FFFF); tick();
    drive_dm_read(32'h8); dm10_q.push_back(32'h55AA_00FF); tick();
    exp_v = dm10_q.pop_front();
    checks++; if (dm_data10 !== exp_v) begin errors++; $display("FAIL oob_pre: got %08h want %08h", dm_data10, exp_v); end
    exp_v = dm_q.pop_front();
    checks++; if (dm_data4 !== exp_v) begin errors++; $display("FAIL oob_pre4: got %08h want %08h", dm_data4, exp_v); end
    checks++; if (oob10 !== 1'b0) begin errors++; $display("FAIL oob_clear: got %b want 0", oob10); end
    drive_dm_read(32'h0000_1000); dm10_q.push_back(32'h0); tick();
    exp_v = dm10_q.pop_front();
    checks++; if (dm_data10 !== exp_v) begin errors++; $display("FAIL oob_rd: got %08h want %08h", dm_data10, exp_v); end
    void'(dm_q.pop_front());
    checks++; if (oob10 !== 1'b1) begin errors++; $display("FAIL oob_set: got %b want 1", oob10); end
    checks++; if (oob4 !== 1'b1) begin errors++; $display("FAIL oob_set4: got %b want 1", oob4); end
    $display("oob read 0x1000: dm=%08h err=%b", dm_data10, oob10);
    drive_dm_write(32'h0000_1000, 32'h1111_1111, 32'hFFFF_FFFF); tick();
    drive_dm_read(32'h0); dm10_q.push_back(32'h0); tick();
    exp_v = dm10_q.pop_front();
    checks++; if (dm_data10 !== exp_v) begin errors++; $display("FAIL oob_drop: got %08h want %08h", dm_data10, exp_v); end
    void'(dm_q.pop_front());
    drive_dm_write(32'h4, 32'h7777_7777, 32'hFFFF_FFFF); tick();
    drive_dm_read(32'h4); dm10_q.push_back(32'h7777_7777); tick();
    exp_v = dm10_q.pop_front();
    checks++; if (dm_data10 !== exp_v) begin errors++; $display("FAIL inrange10: got %08h want %08h", dm_data10, exp_v); end
    void'(dm_q.pop_front());
    checks++; if (oob10 !== 1'b1) begin errors++; $display("FAIL oob_sticky: got %b want 1", oob10); end
    $display("after in-range access: dm=%08h err=%b", dm_data10, oob10);
    bus_idle();
  endtask

  task automatic test_reset_mid_sweep();
    int n;
    rst4 = 1'b0; #1;
    checks++; if (im_data4 !== 32'h0) begin errors++; $display("FAIL rst_im: got %08h want 00000000", im_data4); end
    checks++; if (dm_data4 !== 32'h0) begin errors++; $display("FAIL rst_dm: got %08h want 00000000", dm_data4); end
    checks++; if (oob4 !== 1'b0) begin errors++; $display("FAIL rst_oob: got %b want 0", oob4); end
    tick();
    rst4 = 1'b1;
    repeat (7) tick();
    rst4 = 1'b0; #1;
    checks++; if (busy4 !== SWEEP) begin errors++; $display("FAIL mid_busy: got %b want %b", busy4, SWEEP); end
    tick();
    rst4 = 1'b1;
    n = 0;
    while (busy4 === 1'b1 && n < 100) begin n++; tick(); end
    checks++; if (n != SWEEP4) begin errors++; $display("FAIL resweep_len: got %0d cycles want %0d", n, SWEEP4); end
    checks++; if (oob4 !== 1'b0) begin errors++; $display("FAIL resweep_oob: got %b want 0", oob4); end
    $display("restarted sweep: busy for %0d cycles, err=%b", n, oob4);
    if (SWEEP) begin
      for (int i = 0; i < 16; i++) mdl[i] = 32'h0;
      drive_dm_read(32'h8); tick();
      exp_v = dm_q.pop_front();
      checks++; if (dm_data4 !== exp_v) begin errors++; $display("FAIL resweep_clr: got %08h want %08h", dm_data4, exp_v); end
      bus_idle();
    end
  endtask

  initial begin
    test_reset();
    test_sweep();
    test_write_mask();
    test_rbw();
    test_im_hold();
    test_oob();
    test_reset_mid_sweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/tcm_responder.md
TCM_RESPONDER -- requirements
Module: tcm_responder

Interface
REQ-001 The module SHALL have parameter DEPTH_LOG2, default 10, giving the log2 of the word count of the shared instruction/data array (1024 x 32 bits by default).
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-003 The module SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-004 The module SHALL have port IM_r_addr, input, 16 bits: instruction byte address; the word index is IM_r_addr[DEPTH_LOG2+1:2].
REQ-005 The module SHALL have port IM_ready, input, 1 bit: instruction read request.
REQ-006 The module SHALL have port IM_r_data, output, 32 bits: registered instruction word.
REQ-007 The module SHALL have port DM_c_en, input, 1 bit: data chip enable, active-high.
REQ-008 The module SHALL have port DM_r_en, input, 1 bit: 1 = read, 0 = write, qualified by DM_c_en.
REQ-009 The module SHALL have port DM_w_en, input, 32 bits: per-bit write enable, active-high.
REQ-010 The module SHALL have port DM_addr, input, 32 bits: data byte address; the word index is DM_addr[DEPTH_LOG2+1:2].
REQ-011 The module SHALL have port DM_w_data, input, 32 bits: write data.
REQ-012 The module SHALL have port DM_rd_data, output, 32 bits: registered data read word.
REQ-013 The module SHALL have port mem_busy, output, 1 bit: high while the initialisation sweep runs.
REQ-014 The module SHALL have port dm_oob_err, output, 1 bit: sticky flag for an out-of-range data access.

Function
REQ-015 An instruction read SHALL have 1-cycle latency: IM_ready=1 at edge N loads IM_r_data with mem[index] at edge N.
REQ-016 IM_r_data SHALL hold its value while IM_ready=0.
REQ-017 A data read (DM_c_en=1, DM_r_en=1) SHALL load DM_rd_data with mem[index] at the same edge; DM_rd_data SHALL hold otherwise, including during writes.
REQ-018 A data write (DM_c_en=1, DM_r_en=0) SHALL update, for each bit b, mem[index][b] to DM_w_data[b] where DM_w_en[b]=1 and leave it unchanged where DM_w_en[b]=0.
REQ-019 With DM_c_en=0, no array access and no output change SHALL occur on the data port.
REQ-020 An instruction read and a data write to the same word in the same cycle SHALL be read-before-write: IM_r_data gets the old word, and the next read sees the new word.
REQ-021 A data access with DM_addr[31:DEPTH_LOG2+2] nonzero SHALL be out-of-range: its writes are dropped, its reads load 0, and dm_oob_err is set.
REQ-022 dm_oob_err SHALL remain set until reset.
REQ-023 Upper bits of IM_r_addr beyond the index SHALL be ignored, so addresses wrap modulo the depth.
REQ-024 DM_addr[1:0] and IM_r_addr[1:0] SHALL be ignored (word access only).
REQ-025 The FSM SHALL have two states: INIT and RUN.
REQ-026 In INIT, a DEPTH_LOG2-bit counter SHALL write 0 to mem[counter] each cycle, mem_busy=1, all IM/DM requests are ignored, and the outputs hold 0.
REQ-027 The transition INIT -> RUN SHALL occur at the edge that clears word 2^DEPTH_LOG2-1, with mem_busy low from that edge on.
REQ-028 RUN SHALL be the terminal state until reset.

Reset
REQ-029 rst=0 SHALL immediately force IM_r_data=0, DM_rd_data=0, dm_oob_err=0, sweep counter=0, and the FSM to INIT (or RUN without the macro).
REQ-030 Reset asserted mid-sweep SHALL restart the sweep from word 0.
REQ-031 Reset asserted in RUN SHALL NOT require the array contents to be preserved.
REQ-032 Deassertion SHALL be sampled synchronously; the first access is accepted at the first rising edge after rst=1 and mem_busy=0.

Configuration
REQ-033 Macro TCM_INIT_CLEAR_EN SHALL control the initialisation sweep.
REQ-034 With TCM_INIT_CLEAR_EN defined, the INIT sweep of REQ-026 to REQ-027 SHALL be compiled in, taking 2^DEPTH_LOG2 cycles after reset.
REQ-035 With TCM_INIT_CLEAR_EN undefined, no sweep counter SHALL exist, the FSM SHALL reset directly to RUN, mem_busy SHALL be tied 0, and the array contents after reset SHALL be undefined (loaded by the testbench backdoor).

Verification
REQ-036 The bench SHALL cover: macro defined, DEPTH_LOG2=4, release reset -> mem_busy high for exactly 16 cycles, then reads of all 16 words return 0x00000000.
REQ-037 The bench SHALL cover: write 0xDEADBEEF to DM_addr 0x8 with DM_w_en=0xFFFFFFFF, then write 0x12345678 with DM_w_en=0x0000FFFF -> the DM read of 0x8 returns 0xDEAD5678 one edge later.
REQ-038 The bench SHALL cover: in the same cycle, DM write 0xA5A5A5A5 to 0x10 and IM_ready=1 with IM_r_addr=0x0010 (old word 0) -> IM_r_data=0 and the next IM read =0xA5A5A5A5.
REQ-039 The bench SHALL cover: DM read of 0x00001000 with DEPTH_LOG2=10 -> DM_rd_data=0 and dm_oob_err=1, held after further in-range accesses.
REQ-040 The bench SHALL cover: assert rst at sweep count 7, release -> mem_busy high for a full 2^DEPTH_LOG2 cycles again and dm_oob_err=0.
REQ-041 The bench SHALL cover: IM_ready=0 for 5 cycles while IM_r_addr changes -> IM_r_data is unchanged.
